membus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the CPU memory bus (MemBus_Address / MemBus_Write_Data / MemRead / MemWrite / Device_Read_Data). It shares the single downstream bus between the CPU data port (master 0) and an auxiliary master such as a program loader or debug port (master 1). Each accepted request becomes one registered bus transaction. Transactions to the device region get a fixed number of wait states. Completion is returned as a one-cycle ready pulse with registered read data.

---
 rtl/membus_pkg.sv | 19 +
 rtl/membus_if.sv | 24 ++
 rtl/membus_rr_arb.sv | 23 ++
 rtl/membus_arbiter.sv | 133 +++++++++++++
 tb/tb_membus_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/membus_pkg.sv
// membus_pkg: shared types and defaults for the two-master memory bus arbiter
// Holds the FSM state enum, master index type, wait counter type and
// the default device-region base and wait-state count.
package membus_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef logic midx_t;

    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [31:0] DEV_BASE_DEF = 32'h4000_0000;
    localparam int          DEV_WAIT_DEF = 2;

endpackage

// File: rtl/membus_if.sv
// membus_if: request/response handshake between one bus master and the arbiter
// Ports (signals):
//   req   master -> arbiter  transaction request, held until ready
//   we    master -> arbiter  1 = write, 0 = read
//   addr  master -> arbiter  byte address
//   wdata master -> arbiter  write data
//   ready arbiter -> master  one-cycle completion pulse
//   rdata arbiter -> master  read data, valid while ready is high
interface membus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ready, rdata);
    modport slave  (input req, we, addr, wdata, output ready, rdata);

endinterface

// File: rtl/membus_rr_arb.sv
// membus_rr_arb: combinational 2-request round-robin picker
// Ports:
//   req         in   eligible request vector, bit i = master i
//   last_grant  in   master granted most recently
//   grant_valid out  at least one eligible request
//   grant_idx   out  winning master
module membus_rr_arb
    import membus_pkg::*;
(
    input  logic [1:0] req,
    input  midx_t      last_grant,
    output logic       grant_valid,
    output midx_t      grant_idx
);

    // On a tie the master that did not win last time gets the bus;
    // otherwise the single requester wins (req[1] is its index).
    always_comb begin
        grant_valid = |req;
        grant_idx   = (&req) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/membus_arbiter.sv
// membus_arbiter: two-master arbiter and sequencer for the CPU memory bus
// Ports:
//   clk               in   rising-edge clock
//   reset             in   synchronous active-low reset
//   m0, m1            slave modports of membus_if (CPU data port, aux master)
//   MemBus_Address    out  registered bus address
//   MemBus_Write_Data out  registered bus write data
//   MemRead, MemWrite out  registered, mutually exclusive strobes
//   Device_Read_Data  in   bus read data, sampled on the last strobe cycle
module membus_arbiter
    import membus_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] DEV_BASE = ADDR_W'(DEV_BASE_DEF),
    parameter int                DEV_WAIT = DEV_WAIT_DEF
)(
    input  logic              clk,
    input  logic              reset,
    membus_if.slave           m0,
    membus_if.slave           m1,
    output logic [ADDR_W-1:0] MemBus_Address,
    output logic [DATA_W-1:0] MemBus_Write_Data,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] Device_Read_Data
);

    state_t            state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    midx_t             gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              rdy0_q, rdy0_d;
    logic              rdy1_q, rdy1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              grant_valid;
    midx_t             grant_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    // A master in its ready cycle is masked so a still-held req is not
    // taken as a second transaction.
    membus_rr_arb u_arb (
        .req         ({m1.req & ~rdy1_q, m0.req & ~rdy0_q}),
        .last_grant  (gnt_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign sel_addr  = grant_idx ? m1.addr  : m0.addr;
    assign sel_wdata = grant_idx ? m1.wdata : m0.wdata;
    assign sel_we    = grant_idx ? m1.we    : m0.we;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rdy0_d   = 1'b0;
        rdy1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (state_q == IDLE) begin
            if (grant_valid) begin
                state_d = ACCESS;
                gnt_d   = grant_idx;
                addr_d  = sel_addr;
                wdata_d = sel_wdata;
                rd_d    = ~sel_we;
                wr_d    = sel_we;
                cnt_d   = (sel_addr >= DEV_BASE) ? CNT_W'(DEV_WAIT) : '0;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            // Last strobe cycle: capture read data and complete.
            state_d  = IDLE;
            rd_d     = 1'b0;
            wr_d     = 1'b0;
            rdy0_d   = ~gnt_q;
            rdy1_d   = gnt_q;
            rdata0_d = (rd_q && !gnt_q) ? Device_Read_Data : rdata0_q;
            rdata1_d = (rd_q &&  gnt_q) ? Device_Read_Data : rdata1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gnt_q    <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rdy0_q   <= 1'b0;
            rdy1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rdy0_q   <= rdy0_d;
            rdy1_q   <= rdy1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign MemBus_Address    = addr_q;
    assign MemBus_Write_Data = wdata_q;
    assign MemRead           = rd_q;
    assign MemWrite          = wr_q;
    assign m0.ready          = rdy0_q;
    assign m1.ready          = rdy1_q;
    assign m0.rdata          = rdata0_q;
    assign m1.rdata          = rdata1_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter: directed self-checking bench for membus_arbiter
module tb_membus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] drd = '0;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        mem_rd;
    logic        mem_wr;

    int tests = 0;
    int fails = 0;
    int r0n = 0;
    int r1n = 0;
    int both_bad = 0;

    membus_if m0_if ();
    membus_if m1_if ();

    membus_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .m0                (m0_if),
        .m1                (m1_if),
        .MemBus_Address    (bus_addr),
        .MemBus_Write_Data (bus_wdata),
        .MemRead           (mem_rd),
        .MemWrite          (mem_wr),
        .Device_Read_Data  (drd)
    );

    always #5 clk = ~clk;

    // Pulse counters and strobe exclusivity, sampled at the edge (pre-update values).
    always @(posedge clk) begin
        if (m0_if.ready === 1'b1) r0n++;
        if (m1_if.ready === 1'b1) r1n++;
        if (mem_rd === 1'b1 && mem_wr === 1'b1) both_bad++;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h20; m0_if.wdata = 32'h0;
        m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h30; m1_if.wdata = 32'h0;
        drd = 32'hCAFE_0000;
        tick; tick;
        tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL rst_rd got %b exp 0", mem_rd); end
        tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL rst_wr got %b exp 0", mem_wr); end
        tests++; if (m0_if.ready !== 1'b0 || m1_if.ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b%b exp 00", m0_if.ready, m1_if.ready); end
        tests++; if (bus_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got %h exp 0", bus_addr); end
        tests++; if (bus_wdata !== 32'h0 || m0_if.rdata !== 32'h0 || m1_if.rdata !== 32'h0) begin fails++; $display("FAIL rst_data got %h %h %h exp 0", bus_wdata, m0_if.rdata, m1_if.rdata); end
        reset = 1'b1;
        tick;
        tests++; if (mem_rd !== 1'b1 || bus_addr !== 32'h20) begin fails++; $display("FAIL rst_first_grant got rd=%b addr=%h exp 1 00000020", mem_rd, bus_addr); end
        tick;
        tests++; if (m0_if.ready !== 1'b1 || m0_if.rdata !== 32'hCAFE_0000 || mem_rd !== 1'b0) begin fails++; $display("FAIL rst_m0_done got rdy=%b rdata=%h rd=%b exp 1 cafe0000 0", m0_if.ready, m0_if.rdata, mem_rd); end
        m0_if.req = 1'b0;
        tick;
        tests++; if (mem_rd !== 1'b1 || bus_addr !== 32'h30 || m0_if.ready !== 1'b0) begin fails++; $display("FAIL rst_m1_grant got rd=%b addr=%h rdy0=%b exp 1 00000030 0", mem_rd, bus_addr, m0_if.ready); end
        tick;
        tests++; if (m1_if.ready !== 1'b1 || m1_if.rdata !== 32'hCAFE_0000) begin fails++; $display("FAIL rst_m1_done got rdy=%b rdata=%h exp 1 cafe0000", m1_if.ready, m1_if.rdata); end
        m1_if.req = 1'b0;
        tick;
    endtask

    task automatic test_mem_read;
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h10;
        drd = 32'h1234_5678;
        tick;
        tests++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || bus_addr !== 32'h10) begin fails++; $display("FAIL mrd_strobe got rd=%b wr=%b addr=%h exp 1 0 00000010", mem_rd, mem_wr, bus_addr); end
        tests++; if (m0_if.ready !== 1'b0) begin fails++; $display("FAIL mrd_early_ready got %b exp 0", m0_if.ready); end
        tick;
        tests++; if (m0_if.ready !== 1'b1 || m0_if.rdata !== 32'h1234_5678 || mem_rd !== 1'b0) begin fails++; $display("FAIL mrd_done got rdy=%b rdata=%h rd=%b exp 1 12345678 0", m0_if.ready, m0_if.rdata, mem_rd); end
        m0_if.req = 1'b0;
        tick;
        tests++; if (m0_if.ready !== 1'b0 || mem_rd !== 1'b0) begin fails++; $display("FAIL mrd_after got rdy=%b rd=%b exp 0 0", m0_if.ready, mem_rd); end
    endtask

    task automatic test_boundary;
        m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.addr = 32'h3FFF_FFFC; m0_if.wdata = 32'hDEAD_BEEF;
        drd = 32'h0BAD_0BAD;
        tick;
        tests++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || bus_addr !== 32'h3FFF_FFFC || bus_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bnd_strobe got wr=%b rd=%b addr=%h wd=%h", mem_wr, mem_rd, bus_addr, bus_wdata); end
        tick;
        tests++; if (m0_if.ready !== 1'b1 || mem_wr !== 1'b0) begin fails++; $display("FAIL bnd_mem_latency got rdy=%b wr=%b exp 1 0", m0_if.ready, mem_wr); end
        tests++; if (m0_if.rdata !== 32'h1234_5678) begin fails++; $display("FAIL bnd_write_keeps_rdata got %h exp 12345678", m0_if.rdata); end
        m0_if.req = 1'b0;
        tick;
    endtask

    task automatic test_dev_write;
        m1_if.req = 1'b1; m1_if.we = 1'b1; m1_if.addr = 32'h4000_0000; m1_if.wdata = 32'hA5A5_0001;
        drd = 32'h7777_7777;
        tick;
        m1_if.addr = 32'h0000_0099; m1_if.wdata = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            tests++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || bus_addr !== 32'h4000_0000 || bus_wdata !== 32'hA5A5_0001 || m1_if.ready !== 1'b0) begin fails++; $display("FAIL dwr_window%0d got wr=%b rd=%b addr=%h wd=%h rdy=%b exp 1 0 40000000 a5a50001 0", i, mem_wr, mem_rd, bus_addr, bus_wdata, m1_if.ready); end
            tick;
        end
        tests++; if (m1_if.ready !== 1'b1 || mem_wr !== 1'b0 || m0_if.ready !== 1'b0) begin fails++; $display("FAIL dwr_done got rdy1=%b wr=%b rdy0=%b exp 1 0 0", m1_if.ready, mem_wr, m0_if.ready); end
        tests++; if (m1_if.rdata !== 32'hCAFE_0000) begin fails++; $display("FAIL dwr_keeps_rdata got %h exp cafe0000", m1_if.rdata); end
        m1_if.req = 1'b0;
        tick;
    endtask

    task automatic test_contention;
        int s0, s1;
        logic [31:0] ea;
        s0 = r0n; s1 = r1n;
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h100;
        m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h200;
        for (int t = 0; t < 4; t++) begin
            ea = (t % 2 == 0) ? 32'h100 : 32'h200;
            tick;
            tests++; if (mem_rd !== 1'b1 || bus_addr !== ea || m0_if.ready !== 1'b0 || m1_if.ready !== 1'b0) begin fails++; $display("FAIL cont_grant%0d got rd=%b addr=%h exp 1 %h", t, mem_rd, bus_addr, ea); end
            drd = 32'h1000 + t;
            tick;
            if (t % 2 == 0) begin
                tests++; if (m0_if.ready !== 1'b1 || m1_if.ready !== 1'b0 || m0_if.rdata !== 32'h1000 + t) begin fails++; $display("FAIL cont_ready%0d got rdy=%b%b rdata=%h exp 10 %h", t, m0_if.ready, m1_if.ready, m0_if.rdata, 32'h1000 + t); end
            end else begin
                tests++; if (m1_if.ready !== 1'b1 || m0_if.ready !== 1'b0 || m1_if.rdata !== 32'h1000 + t) begin fails++; $display("FAIL cont_ready%0d got rdy=%b%b rdata=%h exp 01 %h", t, m0_if.ready, m1_if.ready, m1_if.rdata, 32'h1000 + t); end
            end
        end
        m0_if.req = 1'b0; m1_if.req = 1'b0;
        tick;
        tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL cont_idle got rd=%b exp 0", mem_rd); end
        tests++; if (r0n - s0 != 2 || r1n - s1 != 2) begin fails++; $display("FAIL cont_count got %0d %0d exp 2 2", r0n - s0, r1n - s1); end
    endtask

    task automatic test_held_req;
        int s0;
        s0 = r0n;
        m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h44;
        drd = 32'h4444;
        tick;
        tests++; if (mem_rd !== 1'b1) begin fails++; $display("FAIL held_strobe got %b exp 1", mem_rd); end
        tick;
        tests++; if (m0_if.ready !== 1'b1 || m0_if.rdata !== 32'h4444) begin fails++; $display("FAIL held_done got rdy=%b rdata=%h exp 1 00004444", m0_if.ready, m0_if.rdata); end
        tick;
        tests++; if (mem_rd !== 1'b0 || m0_if.ready !== 1'b0) begin fails++; $display("FAIL held_no_dup got rd=%b rdy=%b exp 0 0", mem_rd, m0_if.ready); end
        tick;
        tests++; if (mem_rd !== 1'b1 || bus_addr !== 32'h44) begin fails++; $display("FAIL held_represent got rd=%b addr=%h exp 1 00000044", mem_rd, bus_addr); end
        drd = 32'h5555;
        tick;
        tests++; if (m0_if.ready !== 1'b1 || m0_if.rdata !== 32'h5555) begin fails++; $display("FAIL held_second got rdy=%b rdata=%h exp 1 00005555", m0_if.ready, m0_if.rdata); end
        m0_if.req = 1'b0;
        tick;
        tests++; if (r0n - s0 != 2 || mem_rd !== 1'b0) begin fails++; $display("FAIL held_count got %0d rd=%b exp 2 0", r0n - s0, mem_rd); end
    endtask

    task automatic test_reset_mid;
        int s0, s1;
        s0 = r0n; s1 = r1n;
        m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h5000_0000;
        drd = 32'h9999_9999;
        tick;
        tests++; if (mem_rd !== 1'b1 || bus_addr !== 32'h5000_0000) begin fails++; $display("FAIL rmid_strobe got rd=%b addr=%h exp 1 50000000", mem_rd, bus_addr); end
        tick;
        reset = 1'b0;
        m1_if.req = 1'b0;
        tick;
        tests++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || bus_addr !== 32'h0 || m1_if.ready !== 1'b0 || m0_if.ready !== 1'b0) begin fails++; $display("FAIL rmid_abort got rd=%b wr=%b addr=%h rdy=%b%b exp 0 0 0 00", mem_rd, mem_wr, bus_addr, m0_if.ready, m1_if.ready); end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        tests++; if (r0n - s0 != 0 || r1n - s1 != 0 || mem_rd !== 1'b0 || m1_if.rdata !== 32'h0) begin fails++; $display("FAIL rmid_no_ready got %0d %0d rd=%b rdata=%h exp 0 0 0 0", r0n - s0, r1n - s1, mem_rd, m1_if.rdata); end
    endtask

    initial begin
        test_reset;
        test_mem_read;
        test_boundary;
        test_dev_write;
        test_contention;
        test_held_req;
        test_reset_mid;
        tests++; if (both_bad != 0) begin fails++; $display("FAIL strobe_exclusive got %0d overlaps exp 0", both_bad); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
